// File: rtl/ccm_stream_loader_pkg.sv
// rtl/ccm_stream_loader_pkg.sv - shared types and constants for the CCM stream loader
package ccm_stream_loader_pkg;

  localparam int XLEN = 32;
  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CNT,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_CSUM    = 2'd0,
    ERR_RANGE   = 2'd1,
    ERR_ZERO    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } loader_err_e;

endpackage

// File: rtl/ccm_stream_loader_packer.sv
// rtl/ccm_stream_loader_packer.sv - little-endian byte to 32-bit word packer
module byte_to_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] sr;

  // The fourth byte completes the word combinationally; the loader registers it.
  assign word_valid = in_valid && (idx == 2'd3);
  assign word       = {in_byte, sr};

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      idx <= 2'd0;
      sr  <= 24'd0;
    end else if (in_valid) begin
      idx <= idx + 2'd1;
      sr  <= {in_byte, sr[23:8]};
    end
  end

endmodule

// File: rtl/ccm_stream_loader.sv
// rtl/ccm_stream_loader.sv - framed byte stream to CCM word write port loader
module ccm_stream_loader
  import ccm_stream_loader_pkg::*;
#(
  parameter int         MEM_DEPTH = 1024,
  parameter logic [7:0] MAGIC     = LOADER_MAGIC,
  parameter int         TIMEOUT   = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            clear,
  output logic [XLEN-1:0] mem_waddr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic            core_hold,
  output logic            load_done,
  output logic            load_err,
  output logic [1:0]      err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [XLEN:0] MEM_BYTES = {MEM_DEPTH[XLEN-2:0], 2'b00};

  loader_state_e   state, state_n;
  loader_err_e     err_q, err_n;
  logic            set_err;
  logic [XLEN-1:0] addr, waddr_q, wdata_q, word;
  logic [15:0]     words_left, cnt_n;
  logic [7:0]      n_lo, csum;
  logic [1:0]      hdr_idx;
  logic [TW-1:0]   tmo_cnt;
  logic            wen_q, accept, active, fire, range_bad, pk_valid, word_valid;

  assign accept    = s_valid && s_ready;
  assign active    = state inside {ADDR, CNT, DATA, CSUM};
  assign fire      = active && (tmo_cnt == TW'(TIMEOUT - 1));
  assign cnt_n     = {s_data, n_lo};
  // Bound computed one bit wider than XLEN so a high base address cannot wrap past the check.
  assign range_bad = (addr[1:0] != 2'b00) ||
                     (({1'b0, addr} + {{(XLEN-17){1'b0}}, cnt_n, 2'b00}) > MEM_BYTES);
  assign pk_valid  = accept && (state == DATA) && !fire;

  // A write pending when reset asserts is suppressed immediately.
  assign mem_wen   = wen_q && rst_n;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign err_code  = err_q;

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state != DATA),
    .in_valid   (pk_valid),
    .in_byte    (s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_n   = state;
    err_n     = ERR_CSUM;
    set_err   = 1'b0;
    s_ready   = !(state inside {DONE, ERR});
    core_hold = (state != DONE);
    load_done = (state == DONE);
    load_err  = (state == ERR);
    if (fire) begin
      state_n = ERR;
      err_n   = ERR_TIMEOUT;
      set_err = 1'b1;
    end else begin
      case (state)
        IDLE: if (accept && s_data == MAGIC) state_n = ADDR;
        ADDR: if (accept && hdr_idx == 2'd3) state_n = CNT;
        CNT: begin
          if (accept && hdr_idx[0]) begin
            if (cnt_n == 16'd0) begin
              state_n = ERR;
              err_n   = ERR_ZERO;
              set_err = 1'b1;
            end else if (range_bad) begin
              state_n = ERR;
              err_n   = ERR_RANGE;
              set_err = 1'b1;
            end else begin
              state_n = DATA;
            end
          end
        end
        DATA: if (word_valid && words_left == 16'd1) state_n = CSUM;
        CSUM: begin
          if (accept) begin
            if (s_data == csum) begin
              state_n = DONE;
            end else begin
              state_n = ERR;
              err_n   = ERR_CSUM;
              set_err = 1'b1;
            end
          end
        end
        DONE, ERR: if (clear) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      err_q      <= ERR_CSUM;
      addr       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      words_left <= 16'd0;
      n_lo       <= 8'd0;
      csum       <= 8'd0;
      hdr_idx    <= 2'd0;
      tmo_cnt    <= '0;
    end else begin
      state   <= state_n;
      wen_q   <= word_valid;
      tmo_cnt <= (active && !accept && !fire) ? tmo_cnt + 1'b1 : '0;
      if (set_err) err_q <= err_n;
      else if (clear && (state inside {DONE, ERR})) err_q <= ERR_CSUM;
      if (!fire) begin
        case (state)
          IDLE: begin
            if (accept && s_data == MAGIC) begin
              hdr_idx <= 2'd0;
              csum    <= 8'd0;
            end
          end
          ADDR: begin
            if (accept) begin
              addr    <= {s_data, addr[XLEN-1:8]};
              hdr_idx <= hdr_idx + 2'd1;
            end
          end
          CNT: begin
            if (accept) begin
              n_lo    <= s_data;
              hdr_idx <= hdr_idx + 2'd1;
              if (hdr_idx[0]) words_left <= cnt_n;
            end
          end
          DATA: begin
            if (pk_valid) begin
              csum <= csum ^ s_data;
              if (word_valid) begin
                waddr_q    <= addr;
                wdata_q    <= word;
                addr       <= addr + 32'd4;
                words_left <= words_left - 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccm_stream_loader.sv
// tb/tb_ccm_stream_loader.sv - self-checking bench for ccm_stream_loader
module tb_ccm_stream_loader;

  localparam int DEPTH = 1024;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        clear = 1'b0;
  logic [31:0] mem_waddr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  logic [7:0]  data_q[$];

  always #5 clk = ~clk;

  ccm_stream_loader #(.MEM_DEPTH(DEPTH), .MAGIC(8'hA5), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .clear     (clear),
    .mem_waddr (mem_waddr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      got_addr.push_back(mem_waddr);
      got_data.push_back(mem_wdata);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_clear_and_check(input string name);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests_run++;
    if ({core_hold, load_done, load_err, err_code, s_ready} !== 6'b100001) begin
      tests_failed++;
      $display("FAIL %s_clear: hold/done/err/code/ready=%b required 100001", name,
               {core_hold, load_done, load_err, err_code, s_ready});
    end
  endtask

  // Reference: outcome and write list derived directly from the frame rules.
  task automatic run_frame(input logic [31:0] a, input int n, input logic [7:0] cs,
                           input int maxgap, input string name);
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  x;
    logic [15:0] nn;
    int          code;
    bit          hdr_bad, exp_done;
    longint      span;
    int          waited;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    x = 8'h00; hdr_bad = 1'b0; code = 0; nn = 16'(n);
    span = longint'(a) + 4 * longint'(n);
    if (n == 0) begin
      hdr_bad = 1'b1; code = 2;
    end else if (a[1:0] != 2'b00 || span > longint'(DEPTH) * 4) begin
      hdr_bad = 1'b1; code = 1;
    end else begin
      for (int w = 0; w < n; w++) begin
        exp_addr.push_back(a + 32'(4 * w));
        exp_data.push_back({data_q[4*w+3], data_q[4*w+2], data_q[4*w+1], data_q[4*w]});
      end
    end
    foreach (data_q[i]) x ^= data_q[i];
    exp_done = !hdr_bad && (cs == x);

    drive_byte(8'hA5, $urandom_range(0, maxgap));
    for (int i = 0; i < 4; i++) drive_byte(a[8*i +: 8], $urandom_range(0, maxgap));
    for (int i = 0; i < 2; i++) drive_byte(nn[8*i +: 8], $urandom_range(0, maxgap));
    if (!hdr_bad) begin
      foreach (data_q[i]) drive_byte(data_q[i], $urandom_range(0, maxgap));
      drive_byte(cs, $urandom_range(0, maxgap));
    end
    waited = 0;
    while (load_done !== 1'b1 && load_err !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    repeat (2) tick();

    tests_run++;
    if (load_done !== exp_done || load_err !== !exp_done) begin
      tests_failed++;
      $display("FAIL %s_outcome: done=%b err=%b required done=%b err=%b", name,
               load_done, load_err, exp_done, !exp_done);
    end
    if (!exp_done) begin
      tests_run++;
      if (err_code !== 2'(code)) begin
        tests_failed++;
        $display("FAIL %s_err_code: got %0d required %0d", name, err_code, code);
      end
    end
    tests_run++;
    if (core_hold !== !exp_done || s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_hold_ready: hold=%b ready=%b required hold=%b ready=0", name,
               core_hold, s_ready, !exp_done);
    end
    tests_run++;
    if (got_addr.size() != exp_addr.size()) begin
      tests_failed++;
      $display("FAIL %s_write_count: got %0d required %0d", name, got_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        tests_run++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          tests_failed++;
          $display("FAIL %s_write%0d: got %h@%h required %h@%h", name, i,
                   got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
    pulse_clear_and_check(name);
  endtask

  function automatic logic [7:0] xor_q();
    logic [7:0] x = 8'h00;
    foreach (data_q[i]) x ^= data_q[i];
    return x;
  endfunction

  task automatic fill_random(input int nbytes);
    data_q.delete();
    for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({s_ready, mem_wen, core_hold, load_done, load_err, err_code} !== 7'b1010000 ||
        mem_waddr !== 32'h0 || mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_values: ready/wen/hold/done/err/code=%b addr=%h data=%h required 1010000 0 0",
               {s_ready, mem_wen, core_hold, load_done, load_err, err_code}, mem_waddr, mem_wdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spec_frames();
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(32'h0, 2, 8'h88, 0, "spec_ok");
    run_frame(32'h0, 2, 8'h00, 0, "spec_badcsum");
    data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(32'h2, 1, 8'h04, 0, "misaligned");
    run_frame(32'hFFC, 2, 8'h00, 0, "over_range");
    run_frame(32'hFFC, 1, 8'h04, 0, "last_word");
    run_frame(32'hFFFF_FFFC, 2, 8'h00, 0, "wrap_range");
    data_q.delete();
    run_frame(32'h40, 0, 8'h00, 0, "zero_count");
  endtask

  task automatic test_garbage();
    drive_byte(8'h00, 0);
    drive_byte(8'hFF, 1);
    drive_byte(8'h5A, 0);
    tests_run++;
    if (s_ready !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL garbage_idle: ready=%b done=%b err=%b required 1 0 0", s_ready, load_done, load_err);
    end
    fill_random(4);
    run_frame(32'h80, 1, xor_q(), 1, "after_garbage");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  cs;
    int          n, sel;
    for (int k = 0; k < 24; k++) begin
      n   = $urandom_range(1, 6);
      sel = $urandom_range(0, 7);
      if (sel == 0) a = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'((DEPTH - n + 1 + $urandom_range(0, 3)) * 4);
      else a = 32'($urandom_range(0, DEPTH - n) * 4);
      fill_random(4 * n);
      cs = xor_q();
      if ($urandom_range(0, 4) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
      run_frame(a, n, cs, 2, "rand");
    end
  endtask

  task automatic test_back_to_back();
    fill_random(16);
    run_frame(32'h100, 4, xor_q(), 0, "b2b");
    for (int i = 1; i < got_cyc.size(); i++) begin
      tests_run++;
      if (got_cyc[i] - got_cyc[i-1] != 4) begin
        tests_failed++;
        $display("FAIL b2b_spacing%0d: got %0d cycles required 4", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
  endtask

  task automatic test_timeout();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    drive_byte(8'hA5, 0);
    drive_byte(8'h20, 0); drive_byte(8'h00, 0); drive_byte(8'h00, 0); drive_byte(8'h00, 0);
    drive_byte(8'h01, 0); drive_byte(8'h00, 0);
    drive_byte(8'hDE, 0);
    drive_byte(8'hAD, TMO - 2);
    drive_byte(8'hBE, 0);
    repeat (TMO - 1) tick();
    tests_run++;
    if (load_err !== 1'b0 || s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmo_early: err=%b ready=%b required 0 1", load_err, s_ready);
    end
    tick();
    tests_run++;
    if (load_err !== 1'b1 || err_code !== 2'd3 || core_hold !== 1'b1 || got_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL tmo_fire: err=%b code=%0d hold=%b writes=%0d required 1 3 1 0",
               load_err, err_code, core_hold, got_addr.size());
    end
    pulse_clear_and_check("tmo");
    fill_random(8);
    run_frame(32'h40, 2, xor_q(), 1, "after_tmo");
  endtask

  task automatic test_reset_mid();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    drive_byte(8'hA5, 0);
    drive_byte(8'h10, 0); drive_byte(8'h00, 0); drive_byte(8'h00, 0); drive_byte(8'h00, 0);
    drive_byte(8'h02, 0); drive_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) drive_byte(8'(8'hC0 + i), 0);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (mem_wen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_wen: got %b required 0", mem_wen);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({s_ready, mem_wen, core_hold, load_done, load_err, err_code} !== 7'b1010000 ||
        mem_waddr !== 32'h0 || mem_wdata !== 32'h0 || got_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_state: flags=%b addr=%h data=%h writes=%0d required 1010000 0 0 0",
               {s_ready, mem_wen, core_hold, load_done, load_err, err_code},
               mem_waddr, mem_wdata, got_addr.size());
    end
    rst_n = 1'b1;
    tick();
    fill_random(4);
    run_frame(32'h0, 1, xor_q(), 0, "after_rst");
  endtask

  initial begin
    #1;
    test_reset();
    test_spec_frames();
    test_garbage();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
